sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-style SDRAM controller port (az_*/za_*) between two requesters.
  - Port 0 is the northbridge CPU path.
  - Port 1 is a debug/loader path.
- Serialises commands and tracks outstanding reads in order with a tag FIFO.
- Routes each read return to the port that issued it.
- Sits between the northbridge/debug logic and the SDRAM controller, all in the clk10p0 domain.

Parameters:
- ADDR_W, 22, word address width into the SDRAM controller.
- DATA_W, 16, data width.
- MAX_PEND, 4, maximum outstanding reads (tag FIFO depth, power of 2).
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk10p0  in  1  clock.
- user_reset_button  in  1  asynchronous, active-high reset.
- mN_req  in  1  command request, N = 0,1; held until ack.
- mN_wr  in  1  1 = write, 0 = read.
- mN_addr  in  ADDR_W  word address.
- mN_be_n  in  2  byte enables, active-low.
- mN_wdata  in  DATA_W  write data.
- mN_ack  out  1  one-cycle pulse: command accepted by the controller.
- mN_rdata  out  DATA_W  read data.
- mN_rvalid  out  1  one-cycle pulse: mN_rdata valid.
- az_addr  out  ADDR_W  controller address.
- az_be_n  out  2  controller byte enables.
- az_data  out  DATA_W  controller write data.
- az_rd_n  out  1  controller read strobe, active-low.
- az_wr_n  out  1  controller write strobe, active-low.
- za_data  in  DATA_W  controller read data.
- za_valid  in  1  controller read data valid.
- za_waitrequest  in  1  controller stall.
- pend_cnt  out  log2(MAX_PEND)+1  outstanding read count.
- err_orphan  out  1  sticky: za_valid received with no outstanding read.

Behaviour:
- Reset (async, user_reset_button high) values:
  - State IDLE; az_rd_n = az_wr_n = 1; az_addr/az_be_n/az_data = 0.
  - All ack/rvalid = 0; rdata = 0; pend_cnt = 0; FIFO empty; err_orphan = 0.
  - last_grant = 1, so port 0 wins the first contention.
- All outputs are registered.
- FSM IDLE -> ISSUE -> ACK -> IDLE.
- IDLE, eligibility: port N is eligible if mN_req = 1 and (mN_wr = 1 or pend_cnt < MAX_PEND).
  - Full pending FIFO blocks reads only; writes still issue.
- IDLE, grant:
  - RR_EN = 1, both eligible: grant the port != last_grant.
  - RR_EN = 0, both eligible: port 0 always wins.
  - On grant, latch addr/be_n/wdata/wr and the port id, drive the az strobe (az_rd_n or az_wr_n = 0) next cycle, go ISSUE, update last_grant.
- ISSUE: hold strobe and command stable while za_waitrequest = 1.
  - On a clock edge with za_waitrequest = 0: deassert strobe, pulse mN_ack for the granted port, go ACK.
  - If the command was a read, push the port id into the tag FIFO at the same edge.
- ACK: one dead cycle; mN_ack = 1 for exactly this cycle; then go IDLE.
  - Requester drops or changes req at the end of its ack cycle, so it is not re-granted the same command.
- Throughput: 3 cycles per command minimum (IDLE, ISSUE, ACK) with no wait-states.
- Read return on za_valid = 1:
  - If FIFO non-empty: pop head tag; next cycle mT_rdata = za_data and mT_rvalid = 1 for tag T. Latency is 1 cycle from za_valid.
  - Non-addressed port's rdata holds its previous value.
- Orphan return: za_valid with FIFO empty sets err_orphan (sticky until reset), the data is dropped, and no rvalid is generated.
- Returns are strictly in issue order; no reordering.
- Simultaneous read push (ISSUE accept) and pop (za_valid) in the same cycle: pend_cnt unchanged; FIFO pointers both advance.
  - When empty, push and pop together is not a legal pop (data has not returned yet): treat as push plus orphan.
- pend_cnt: +1 on push only, -1 on pop only; never exceeds MAX_PEND.
- FIFO pointers wrap modulo MAX_PEND.
- Reset mid-operation: the strobe is deasserted immediately (async) and the pending tags are discarded. The controller shares the reset, so no returns are expected afterwards; any stray return flags err_orphan.

Decomposition:
- Package sdram_arb_pkg:
  - State enum (IDLE, ISSUE, ACK).
  - Port id constants PORT_CPU = 0, PORT_DBG = 1.
  - Default widths ADDR_W/DATA_W.
- Sub-module sdram_tag_fifo:
  - Parameters MAX_PEND; 1-bit data.
  - Ports: push, pop, din, dout, empty, full, count.
  - Reset to empty.

Test Plan:
- Single port-0 write, addr 0x000123, data 0xBEEF, be_n 00, waitrequest low -> az_wr_n low exactly 1 cycle with those values; m0_ack 1 cycle later; pend_cnt stays 0.
- Port-1 read to 0x3FFFFF, controller returns 0x1234 three cycles later -> m1_rvalid pulses 1 cycle after za_valid with m1_rdata = 0x1234; m0_rvalid stays 0; pend_cnt 1 -> 0.
- Both ports requesting reads continuously, RR_EN = 1 -> grants alternate 0, 1, 0, 1. With RR_EN = 0 -> port 0 every grant while requesting.
- Five back-to-back reads, MAX_PEND = 4, returns withheld -> 4 strobes issued, pend_cnt = 4, 5th read stalls. A queued write from the other port still issues. After one za_valid the 5th read issues.
- za_waitrequest held high 7 cycles during ISSUE -> az command stable all 7 cycles; ack only after release. Interleaved returns routed by tag order (issue 0, 1, 0 -> rvalid on 0, 1, 0).
- za_valid with pend_cnt = 0 -> err_orphan = 1, no rvalid. Assert user_reset_button mid-ISSUE -> strobes high, pend_cnt 0, err_orphan 0 immediately.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM controller arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StAck
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned DEF_ADDR_W = 22;
    localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Ordered FIFO of 1-bit port tags, one entry per outstanding SDRAM read.
module sdram_tag_fifo #(
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                       clk10p0,
    input  logic                       user_reset_button,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       din,
    output logic                       dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(MAX_PEND):0]  count
);

    localparam int unsigned PtrW = $clog2(MAX_PEND);
    localparam logic [PtrW:0] FullCnt = MAX_PEND[PtrW:0];

    logic [MAX_PEND-1:0] mem_q;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCnt);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk10p0 or posedge user_reset_button) begin
        if (user_reset_button) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of the Avalon-style SDRAM controller port;
// read returns are steered back to their issuer through an in-order tag FIFO.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_PEND = 4,
    parameter int unsigned RR_EN    = 1
) (
    input  logic                      clk10p0,
    input  logic                      user_reset_button,
    input  logic                      m0_req,
    input  logic                      m0_wr,
    input  logic [ADDR_W-1:0]         m0_addr,
    input  logic [1:0]                m0_be_n,
    input  logic [DATA_W-1:0]         m0_wdata,
    output logic                      m0_ack,
    output logic [DATA_W-1:0]         m0_rdata,
    output logic                      m0_rvalid,
    input  logic                      m1_req,
    input  logic                      m1_wr,
    input  logic [ADDR_W-1:0]         m1_addr,
    input  logic [1:0]                m1_be_n,
    input  logic [DATA_W-1:0]         m1_wdata,
    output logic                      m1_ack,
    output logic [DATA_W-1:0]         m1_rdata,
    output logic                      m1_rvalid,
    output logic [ADDR_W-1:0]         az_addr,
    output logic [1:0]                az_be_n,
    output logic [DATA_W-1:0]         az_data,
    output logic                      az_rd_n,
    output logic                      az_wr_n,
    input  logic [DATA_W-1:0]         za_data,
    input  logic                      za_valid,
    input  logic                      za_waitrequest,
    output logic [$clog2(MAX_PEND):0] pend_cnt,
    output logic                      err_orphan
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d, wr_q, wr_d, last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        be_n_q, be_n_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              orphan_q, orphan_d;
    logic              elig0, elig1, sel, sel_wr;
    logic              tag_push, tag_pop, tag_dout, tag_empty, tag_full;

    // Reads need a free tag slot; writes never occupy one.
    assign elig0   = m0_req && (m0_wr || !tag_full);
    assign elig1   = m1_req && (m1_wr || !tag_full);
    assign tag_pop = za_valid && !tag_empty;

    sdram_tag_fifo #(
        .MAX_PEND(MAX_PEND)
    ) u_tag_fifo (
        .clk10p0          (clk10p0),
        .user_reset_button(user_reset_button),
        .push             (tag_push),
        .pop              (tag_pop),
        .din              (grant_q),
        .dout             (tag_dout),
        .empty            (tag_empty),
        .full             (tag_full),
        .count            (pend_cnt)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        wr_d         = wr_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        be_n_d       = be_n_q;
        data_d       = data_q;
        rd_n_d       = rd_n_q;
        wr_n_d       = wr_n_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tag_push     = 1'b0;
        sel          = PORT_CPU;
        sel_wr       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (elig0 && elig1) begin
                    sel = (RR_EN != 0) ? ~last_grant_q : PORT_CPU;
                end else begin
                    sel = elig1 ? PORT_DBG : PORT_CPU;
                end
                sel_wr = (sel == PORT_DBG) ? m1_wr : m0_wr;
                if (elig0 || elig1) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    wr_d         = sel_wr;
                    addr_d       = (sel == PORT_DBG) ? m1_addr : m0_addr;
                    be_n_d       = (sel == PORT_DBG) ? m1_be_n : m0_be_n;
                    data_d       = (sel == PORT_DBG) ? m1_wdata : m0_wdata;
                    rd_n_d       = sel_wr;
                    wr_n_d       = ~sel_wr;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (!za_waitrequest) begin
                    rd_n_d   = 1'b1;
                    wr_n_d   = 1'b1;
                    ack0_d   = (grant_q == PORT_CPU);
                    ack1_d   = (grant_q == PORT_DBG);
                    tag_push = ~wr_q;
                    state_d  = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A return with no tag outstanding (including one racing its own push) is an orphan.
    always_comb begin
        rvalid0_d = tag_pop && (tag_dout == PORT_CPU);
        rvalid1_d = tag_pop && (tag_dout == PORT_DBG);
        rdata0_d  = rvalid0_d ? za_data : rdata0_q;
        rdata1_d  = rvalid1_d ? za_data : rdata1_q;
        orphan_d  = orphan_q || (za_valid && tag_empty);
    end

    always_ff @(posedge clk10p0 or posedge user_reset_button) begin
        if (user_reset_button) begin
            state_q      <= StIdle;
            grant_q      <= PORT_CPU;
            wr_q         <= 1'b0;
            last_grant_q <= PORT_DBG;
            addr_q       <= '0;
            be_n_q       <= '0;
            data_q       <= '0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            orphan_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            wr_q         <= wr_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            be_n_q       <= be_n_d;
            data_q       <= data_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            orphan_q     <= orphan_d;
        end
    end

    assign az_addr    = addr_q;
    assign az_be_n    = be_n_q;
    assign az_data    = data_q;
    assign az_rd_n    = rd_n_q;
    assign az_wr_n    = wr_n_q;
    assign m0_ack     = ack0_q;
    assign m1_ack     = ack1_q;
    assign m0_rvalid  = rvalid0_q;
    assign m1_rvalid  = rvalid1_q;
    assign m0_rdata   = rdata0_q;
    assign m1_rdata   = rdata1_q;
    assign err_orphan = orphan_q;

endmodule
